tv80_bus_tracer: RTL and testbench

Passive downstream observer of the tv80s CPU bus; decodes every completed bus cycle (opcode fetch, mem read/write, IO read/write, interrupt ack) into a trace record and buffers records in a FIFO. Sits beside the memory/IO models in CPU instruction benches and FPGA debug builds. Benches drain the FIFO to check instruction bus behaviour, e.g. CB-prefixed fetch sequences, in addition to final register state.

---
 rtl/tv80_bus_tracer.sv | 231 +++++++++++++++++++++++
 tb/tb_tv80_bus_tracer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tv80_bus_tracer.sv
// tv80_bus_tracer: passive tv80s bus observer, one record per completed cycle.
// Define TRACE_TIMESTAMP_EN to add a per-record 16-bit start-cycle stamp (trc_time).
module tv80_bus_tracer #(
  parameter int DEPTH = 16,
  parameter int AW    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trace_en,
  input  logic                   clear,
  input  logic [AW-1:0]          cpu_a,
  input  logic [7:0]             cpu_di,
  input  logic [7:0]             cpu_do,
  input  logic                   cpu_m1_n,
  input  logic                   cpu_mreq_n,
  input  logic                   cpu_iorq_n,
  input  logic                   cpu_rd_n,
  input  logic                   cpu_wr_n,
  input  logic                   cpu_rfsh_n,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output logic [2:0]             trc_kind,
  output logic [AW-1:0]          trc_addr,
  output logic [7:0]             trc_data,
  output logic [$clog2(DEPTH):0] trc_count,
  output logic                   overflow,
  output logic [7:0]             drop_count,
`ifdef TRACE_TIMESTAMP_EN
  output logic [15:0]            trc_time,
`endif
  output logic [15:0]            m1_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] K_OPF  = 3'd0;
  localparam logic [2:0] K_MRD  = 3'd1;
  localparam logic [2:0] K_MWR  = 3'd2;
  localparam logic [2:0] K_IORD = 3'd3;
  localparam logic [2:0] K_IOWR = 3'd4;
  localparam logic [2:0] K_INTA = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPT,
    S_SKIP
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic            w_active;
  logic            w_start;
  logic            w_push;
  logic [2:0]      w_kind;
  logic            w_kind_wr;
  logic            w_rec_wr;

  logic [2:0]      r_kind;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_data;

  logic [2:0]      r_mk [DEPTH];
  logic [AW-1:0]   r_ma [DEPTH];
  logic [7:0]      r_md [DEPTH];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [PW-1:0]   w_rp_nx;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nx;
  logic            w_full;
  logic            w_pop;
  logic            w_wr;
  logic            w_drop;
  logic            w_new_hd;

  logic [2:0]      w_hk;
  logic [AW-1:0]   w_ha;
  logic [7:0]      w_hd;
  logic [2:0]      r_ok;
  logic [AW-1:0]   r_oa;
  logic [7:0]      r_od;
  logic            r_ovf;
  logic [7:0]      r_drop;
  logic [15:0]     r_m1;

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0]     r_time;
  logic [15:0]     r_ts;
  logic [15:0]     r_mt [DEPTH];
  logic [15:0]     w_ht;
  logic [15:0]     r_ot;
`endif

  // Refresh cycles are excluded outright by rfsh_n.
  assign w_active = cpu_rfsh_n &
    ((~cpu_mreq_n & (~cpu_rd_n | ~cpu_wr_n)) |
     (~cpu_iorq_n & (~cpu_rd_n | ~cpu_wr_n | ~cpu_m1_n)));

  always_comb begin
    w_kind = K_IORD;
    if (!cpu_m1_n && !cpu_iorq_n)       w_kind = K_INTA;
    else if (!cpu_m1_n && !cpu_mreq_n)  w_kind = K_OPF;
    else if (!cpu_mreq_n && !cpu_wr_n)  w_kind = K_MWR;
    else if (!cpu_mreq_n)               w_kind = K_MRD;
    else if (!cpu_iorq_n && !cpu_wr_n)  w_kind = K_IOWR;
  end

  assign w_kind_wr = (w_kind == K_MWR) | (w_kind == K_IOWR);
  assign w_rec_wr  = (r_kind == K_MWR) | (r_kind == K_IOWR);

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_push     = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_active) begin
        w_state_nx = trace_en ? S_CAPT : S_SKIP;
        w_start    = trace_en;
      end
      S_CAPT: if (!w_active) begin
        w_state_nx = S_IDLE;
        w_push     = 1'b1;
      end
      S_SKIP: if (!w_active) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) r_state <= S_IDLE;
    else                r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_kind <= K_OPF;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_start) begin
      r_kind <= w_kind;
      r_addr <= cpu_a;
      r_data <= w_kind_wr ? cpu_do : cpu_di;
    end else if (r_state == S_CAPT && w_active) begin
      r_data <= w_rec_wr ? cpu_do : cpu_di;
    end
  end

  assign w_full   = (r_cnt == CW'(DEPTH));
  assign w_pop    = (r_cnt != '0) & trc_ready;
  assign w_wr     = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;
  assign w_rp_nx  = w_pop ? r_rp + PW'(1) : r_rp;
  // An empty (or draining-to-empty) FIFO presents the incoming record directly.
  assign w_new_hd = w_wr & ((r_cnt == '0) | ((r_cnt == CW'(1)) & w_pop));

  always_comb begin
    w_cnt_nx = r_cnt;
    if (w_wr && !w_pop)      w_cnt_nx = r_cnt + CW'(1);
    else if (!w_wr && w_pop) w_cnt_nx = r_cnt - CW'(1);
  end

  assign w_hk = w_new_hd ? r_kind : r_mk[w_rp_nx];
  assign w_ha = w_new_hd ? r_addr : r_ma[w_rp_nx];
  assign w_hd = w_new_hd ? r_data : r_md[w_rp_nx];

  always_ff @(posedge clk) begin
    if (w_wr && !reset && !clear) begin
      r_mk[r_wp] <= r_kind;
      r_ma[r_wp] <= r_addr;
      r_md[r_wp] <= r_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ok   <= '0;
      r_oa   <= '0;
      r_od   <= '0;
      r_ovf  <= 1'b0;
      r_drop <= '0;
      r_m1   <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + PW'(1);
      r_rp  <= w_rp_nx;
      r_cnt <= w_cnt_nx;
      if (w_cnt_nx != '0) begin
        r_ok <= w_hk;
        r_oa <= w_ha;
        r_od <= w_hd;
      end
      if (w_drop) r_ovf <= 1'b1;
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      if (w_push && r_kind == K_OPF) r_m1 <= r_m1 + 16'd1;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  assign w_ht = w_new_hd ? r_ts : r_mt[w_rp_nx];

  always_ff @(posedge clk) begin
    if (w_wr && !reset && !clear) r_mt[r_wp] <= r_ts;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_time <= '0;
      r_ts   <= '0;
      r_ot   <= '0;
    end else begin
      r_time <= r_time + 16'd1;
      if (w_start) r_ts <= r_time;
      if (w_cnt_nx != '0) r_ot <= w_ht;
    end
  end

  assign trc_time = r_ot;
`endif

  assign trc_valid  = (r_cnt != '0);
  assign trc_count  = r_cnt;
  assign trc_kind   = r_ok;
  assign trc_addr   = r_oa;
  assign trc_data   = r_od;
  assign overflow   = r_ovf;
  assign drop_count = r_drop;
  assign m1_count   = r_m1;

endmodule

// File: tb/tb_tv80_bus_tracer.sv
// tb_tv80_bus_tracer: directed tv80 bus-cycle stimulus against a queue model
// of the trace FIFO, compared every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_tv80_bus_tracer;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam logic [2:0] K_OPF  = 3'd0;
  localparam logic [2:0] K_MRD  = 3'd1;
  localparam logic [2:0] K_MWR  = 3'd2;
  localparam logic [2:0] K_IORD = 3'd3;
  localparam logic [2:0] K_IOWR = 3'd4;
  localparam logic [2:0] K_INTA = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic trace_en = 1'b0;
  logic clear = 1'b0;
  logic trc_ready = 1'b0;
  logic [AW-1:0] cpu_a = '0;
  logic [7:0] cpu_di = '0;
  logic [7:0] cpu_do = '0;
  logic m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
  logic rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;

  logic          trc_valid;
  logic [2:0]    trc_kind;
  logic [AW-1:0] trc_addr;
  logic [7:0]    trc_data;
  logic [2:0]    trc_count;
  logic          overflow;
  logic [7:0]    drop_count;
  logic [15:0]   m1_count;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0]   trc_time;
`endif

  tv80_bus_tracer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .trace_en(trace_en), .clear(clear),
    .cpu_a(cpu_a), .cpu_di(cpu_di), .cpu_do(cpu_do),
    .cpu_m1_n(m1_n), .cpu_mreq_n(mreq_n), .cpu_iorq_n(iorq_n),
    .cpu_rd_n(rd_n), .cpu_wr_n(wr_n), .cpu_rfsh_n(rfsh_n),
    .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_kind(trc_kind), .trc_addr(trc_addr), .trc_data(trc_data),
    .trc_count(trc_count), .overflow(overflow), .drop_count(drop_count),
`ifdef TRACE_TIMESTAMP_EN
    .trc_time(trc_time),
`endif
    .m1_count(m1_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  k;
    logic [15:0] a;
    logic [7:0]  d;
    logic [15:0] t;
  } rec_t;

  rec_t        q[$];
  rec_t        last_head = '0;
  rec_t        m_rec = '0;
  bit          m_push = 0;
  bit          m_pop, m_full, m_ovf = 0;
  int unsigned m_m1 = 0, m_drop = 0;
  logic [15:0] m_tcnt = '0;
  bit          pop_at_push = 0;
  bit          run_chk = 0;
  int          errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference FIFO: a record arrives at the edge ending its bus cycle.
  always @(posedge clk) begin
    if (reset || clear) begin
      q.delete();
      last_head = '0;
      m_m1 = 0;
      m_drop = 0;
      m_ovf = 0;
      m_tcnt = '0;
    end else begin
      m_pop  = trc_ready && q.size() > 0;
      m_full = q.size() == DEPTH;
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        if (m_rec.k == K_OPF) m_m1 = (m_m1 + 1) % 65536;
        if (m_full && !m_pop) begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end else q.push_back(m_rec);
      end
      if (q.size() > 0) last_head = q[0];
      m_tcnt = m_tcnt + 16'd1;
    end
  end

  always @(negedge clk) if (run_chk) begin
    chk("valid", trc_valid, q.size() != 0);
    chk("count", trc_count, q.size());
    chk("kind", trc_kind, last_head.k);
    chk("addr", trc_addr, last_head.a);
    chk("data", trc_data, last_head.d);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drop);
    chk("m1_count", m1_count, m_m1 & 32'hFFFF);
`ifdef TRACE_TIMESTAMP_EN
    chk("trc_time", trc_time, last_head.t);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    m1_n = 1; mreq_n = 1; iorq_n = 1;
    rd_n = 1; wr_n = 1; rfsh_n = 1;
  endtask

  // One bus cycle active for n edges; data settles only on the last edge.
  task automatic cyc(input logic [2:0] k, input logic [15:0] a,
                     input logic [7:0] d, input int n, input bit rf,
                     input bit en_mid);
    rec_t r;
    bit   en0;
    bit   wr;
    en0 = trace_en;
    r.k = k; r.a = a; r.d = d; r.t = m_tcnt;
    wr = (k == K_MWR) || (k == K_IOWR);
    cpu_a = a;
    case (k)
      K_OPF:  begin m1_n = 0; mreq_n = 0; rd_n = 0; end
      K_MRD:  begin mreq_n = 0; rd_n = 0; end
      K_MWR:  begin mreq_n = 0; wr_n = 0; end
      K_IORD: begin iorq_n = 0; rd_n = 0; end
      K_IOWR: begin iorq_n = 0; wr_n = 0; end
      default: begin m1_n = 0; iorq_n = 0; end
    endcase
    for (int i = 0; i < n; i++) begin
      if (wr) begin
        cpu_do = (i == n - 1) ? d : d ^ 8'h5A;
        cpu_di = ~d;
      end else begin
        cpu_di = (i == n - 1) ? d : d ^ 8'h5A;
        cpu_do = ~d;
      end
      step();
      if (i == 0) trace_en = en_mid;
    end
    idle_bus();
    cpu_a = 16'h007F;
    if (rf) begin rfsh_n = 0; mreq_n = 0; end
    m_push = en0;
    m_rec  = r;
    if (pop_at_push) trc_ready = 1;
    step();
    m_push = 0;
    if (pop_at_push) trc_ready = 0;
    if (rf) begin
      step();
      idle_bus();
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    trc_ready = 1;
    while (q.size() != 0 && g < 40) begin
      step();
      g++;
    end
    trc_ready = 0;
    chk("drain_empty", trc_valid, 0);
  endtask

  task automatic pop1();
    trc_ready = 1;
    step();
    trc_ready = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_bus();
    step();
    run_chk = 1;
    step();
    step();
    @(negedge clk);
    chk("rst_valid", trc_valid, 0);
    chk("rst_count", trc_count, 0);
    chk("rst_m1", m1_count, 0);
    chk("rst_addr", trc_addr, 0);
    step();
    reset = 0;
    trace_en = 1;

    // CB-prefixed fetch pair with refresh after each M1.
    cyc(K_OPF, 16'h0000, 8'hCB, 2, 1, 1);
    cyc(K_OPF, 16'h0001, 8'hE9, 2, 1, 1);
    repeat (8) step();
    @(negedge clk);
    chk("cb_count", trc_count, 2);
    chk("cb_m1", m1_count, 2);
    chk("cb_head_data", trc_data, 8'hCB);
    chk("cb_head_kind", trc_kind, K_OPF);
    pop1();
    @(negedge clk);
    chk("cb_2nd_addr", trc_addr, 16'h0001);
    chk("cb_2nd_data", trc_data, 8'hE9);
    drain();

    // LD (HL),A
    cyc(K_OPF, 16'h0000, 8'h77, 2, 1, 1);
    cyc(K_MWR, 16'hA4D0, 8'h57, 2, 0, 1);
    pop1();
    @(negedge clk);
    chk("ld_mwr_kind", trc_kind, K_MWR);
    chk("ld_mwr_addr", trc_addr, 16'hA4D0);
    chk("ld_mwr_data", trc_data, 8'h57);
    drain();

    // OUT (12),A then IN and interrupt acknowledge, back to back.
    cyc(K_OPF, 16'h0000, 8'hD3, 2, 1, 1);
    cyc(K_MRD, 16'h0001, 8'h12, 2, 0, 1);
    cyc(K_IOWR, 16'h5712, 8'h57, 3, 0, 1);
    @(negedge clk);
    chk("out_count", trc_count, 3);
    drain();
    cyc(K_IORD, 16'h00FE, 8'h3C, 2, 0, 1);
    cyc(K_INTA, 16'h00FF, 8'hC7, 2, 0, 1);
    @(negedge clk);
    chk("io_head_kind", trc_kind, K_IORD);
    chk("io_head_data", trc_data, 8'h3C);
    drain();

    // Overflow with DEPTH=4 and no consumer.
    clear = 1;
    step();
    clear = 0;
    cyc(K_OPF, 16'h0000, 8'h00, 2, 1, 1);
    cyc(K_OPF, 16'h0001, 8'h00, 2, 1, 1);
    cyc(K_MWR, 16'h8000, 8'h11, 2, 0, 1);
    cyc(K_OPF, 16'h0002, 8'h00, 2, 1, 1);
    cyc(K_MWR, 16'h8001, 8'h22, 2, 0, 1);
    cyc(K_OPF, 16'h0003, 8'h00, 2, 1, 1);
    @(negedge clk);
    chk("ovf_count", trc_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 2);
    chk("ovf_m1", m1_count, 4);
    chk("ovf_head_addr", trc_addr, 16'h0000);
    pop_at_push = 1;
    cyc(K_OPF, 16'h0004, 8'h00, 2, 1, 1);
    pop_at_push = 0;
    @(negedge clk);
    chk("pp_count", trc_count, 4);
    chk("pp_drops", drop_count, 2);
    chk("pp_m1", m1_count, 5);
    chk("pp_head_addr", trc_addr, 16'h0001);

    // Clear while full.
    step();
    clear = 1;
    step();
    clear = 0;
    @(negedge clk);
    chk("clr_valid", trc_valid, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_drops", drop_count, 0);
    chk("clr_m1", m1_count, 0);

    // Skipped first fetch (enable rises mid-cycle), captured second fetch,
    // then a read whose enable falls mid-capture.
    step();
    trace_en = 0;
    cyc(K_OPF, 16'h0000, 8'hCB, 2, 1, 1);
    cyc(K_OPF, 16'h0001, 8'hE9, 2, 1, 1);
    @(negedge clk);
    chk("en_count", trc_count, 1);
    chk("en_head_addr", trc_addr, 16'h0001);
    chk("en_head_data", trc_data, 8'hE9);
    chk("en_m1", m1_count, 1);
    step();
    cyc(K_MRD, 16'h0002, 8'h44, 3, 0, 0);
    trace_en = 1;
    @(negedge clk);
    chk("enfall_count", trc_count, 2);
    step();
    drain();

    // Reset during a memory write capture.
    cpu_a = 16'hA4D0;
    cpu_do = 8'h57;
    mreq_n = 0;
    wr_n = 0;
    step();
    step();
    reset = 1;
    step();
    idle_bus();
    step();
    reset = 0;
    cyc(K_OPF, 16'h0000, 8'hCB, 2, 1, 1);
    @(negedge clk);
    chk("rstc_count", trc_count, 1);
    chk("rstc_kind", trc_kind, K_OPF);
    chk("rstc_addr", trc_addr, 16'h0000);
`ifdef TRACE_TIMESTAMP_EN
    chk("rstc_time", trc_time, 16'd0);
`endif
    step();
    drain();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
